// File: rtl/trigonometry_unit.sv
// Two-stage sine/cosine generator: integer-degree angle in, round(1024*sin/cos) out.
// Quarter-wave LUT indexed after quadrant folding; signs applied in the output stage.
module trigonometry_unit (
  input  logic        i_CLK,
  input  logic        i_RESET,
  input  logic [31:0] i_theta,
  output logic [31:0] o_cos,
  output logic [31:0] o_sin
);

  localparam logic [31:0] SCALE = 32'd1024;

  typedef enum logic [1:0] {
    QUAD_0 = 2'd0,  // 0..90
    QUAD_1 = 2'd1,  // 91..180
    QUAD_2 = 2'd2,  // 181..270
    QUAD_3 = 2'd3   // 271..359
  } quad_t;

  function automatic logic [10:0] sin_lut(input logic [6:0] k);
    case (k)
      7'd0:  sin_lut = 11'd0;
      7'd1:  sin_lut = 11'd18;
      7'd2:  sin_lut = 11'd36;
      7'd3:  sin_lut = 11'd54;
      7'd4:  sin_lut = 11'd71;
      7'd5:  sin_lut = 11'd89;
      7'd6:  sin_lut = 11'd107;
      7'd7:  sin_lut = 11'd125;
      7'd8:  sin_lut = 11'd143;
      7'd9:  sin_lut = 11'd160;
      7'd10: sin_lut = 11'd178;
      7'd11: sin_lut = 11'd195;
      7'd12: sin_lut = 11'd213;
      7'd13: sin_lut = 11'd230;
      7'd14: sin_lut = 11'd248;
      7'd15: sin_lut = 11'd265;
      7'd16: sin_lut = 11'd282;
      7'd17: sin_lut = 11'd299;
      7'd18: sin_lut = 11'd316;
      7'd19: sin_lut = 11'd333;
      7'd20: sin_lut = 11'd350;
      7'd21: sin_lut = 11'd367;
      7'd22: sin_lut = 11'd384;
      7'd23: sin_lut = 11'd400;
      7'd24: sin_lut = 11'd416;
      7'd25: sin_lut = 11'd433;
      7'd26: sin_lut = 11'd449;
      7'd27: sin_lut = 11'd465;
      7'd28: sin_lut = 11'd481;
      7'd29: sin_lut = 11'd496;
      7'd30: sin_lut = 11'd512;
      7'd31: sin_lut = 11'd527;
      7'd32: sin_lut = 11'd543;
      7'd33: sin_lut = 11'd558;
      7'd34: sin_lut = 11'd573;
      7'd35: sin_lut = 11'd587;
      7'd36: sin_lut = 11'd602;
      7'd37: sin_lut = 11'd616;
      7'd38: sin_lut = 11'd630;
      7'd39: sin_lut = 11'd644;
      7'd40: sin_lut = 11'd658;
      7'd41: sin_lut = 11'd672;
      7'd42: sin_lut = 11'd685;
      7'd43: sin_lut = 11'd698;
      7'd44: sin_lut = 11'd711;
      7'd45: sin_lut = 11'd724;
      7'd46: sin_lut = 11'd737;
      7'd47: sin_lut = 11'd749;
      7'd48: sin_lut = 11'd761;
      7'd49: sin_lut = 11'd773;
      7'd50: sin_lut = 11'd784;
      7'd51: sin_lut = 11'd796;
      7'd52: sin_lut = 11'd807;
      7'd53: sin_lut = 11'd818;
      7'd54: sin_lut = 11'd828;
      7'd55: sin_lut = 11'd839;
      7'd56: sin_lut = 11'd849;
      7'd57: sin_lut = 11'd859;
      7'd58: sin_lut = 11'd868;
      7'd59: sin_lut = 11'd878;
      7'd60: sin_lut = 11'd887;
      7'd61: sin_lut = 11'd896;
      7'd62: sin_lut = 11'd904;
      7'd63: sin_lut = 11'd912;
      7'd64: sin_lut = 11'd920;
      7'd65: sin_lut = 11'd928;
      7'd66: sin_lut = 11'd935;
      7'd67: sin_lut = 11'd943;
      7'd68: sin_lut = 11'd949;
      7'd69: sin_lut = 11'd956;
      7'd70: sin_lut = 11'd962;
      7'd71: sin_lut = 11'd968;
      7'd72: sin_lut = 11'd974;
      7'd73: sin_lut = 11'd979;
      7'd74: sin_lut = 11'd984;
      7'd75: sin_lut = 11'd989;
      7'd76: sin_lut = 11'd994;
      7'd77: sin_lut = 11'd998;
      7'd78: sin_lut = 11'd1002;
      7'd79: sin_lut = 11'd1005;
      7'd80: sin_lut = 11'd1008;
      7'd81: sin_lut = 11'd1011;
      7'd82: sin_lut = 11'd1014;
      7'd83: sin_lut = 11'd1016;
      7'd84: sin_lut = 11'd1018;
      7'd85: sin_lut = 11'd1020;
      7'd86: sin_lut = 11'd1022;
      7'd87: sin_lut = 11'd1023;
      7'd88: sin_lut = 11'd1023;
      7'd89: sin_lut = 11'd1024;
      7'd90: sin_lut = 11'd1024;
      default: sin_lut = 11'd0;  // indices 91..127 are never produced by the folding
    endcase
  endfunction

  // Angle reduction: 9-bit angle folded into 0..359.
  logic [8:0]  w_angle;
  quad_t       w_quad;
  logic [8:0]  w_sin_full;
  logic [8:0]  w_cos_full;
  logic        w_unused;

  assign w_angle = (i_theta[8:0] >= 9'd360) ? (i_theta[8:0] - 9'd360) : i_theta[8:0];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_quad     = QUAD_0;
    w_sin_full = w_angle;
    w_cos_full = 9'd90 - w_angle;
    if (w_angle <= 9'd90) begin
      w_quad     = QUAD_0;
      w_sin_full = w_angle;
      w_cos_full = 9'd90 - w_angle;
    end else if (w_angle <= 9'd180) begin
      w_quad     = QUAD_1;
      w_sin_full = 9'd180 - w_angle;
      w_cos_full = w_angle - 9'd90;
    end else if (w_angle <= 9'd270) begin
      w_quad     = QUAD_2;
      w_sin_full = w_angle - 9'd180;
      w_cos_full = 9'd270 - w_angle;
    end else begin
      w_quad     = QUAD_3;
      w_sin_full = 9'd360 - w_angle;
      w_cos_full = w_angle - 9'd270;
    end
  end

  // Upper angle bits are ignored; folded indices never exceed 90, so bits 8:7 are always zero.
  assign w_unused = ^{i_theta[31:9], w_sin_full[8:7], w_cos_full[8:7]};

  quad_t       r_quad;
  logic [6:0]  r_sin_idx;
  logic [6:0]  r_cos_idx;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      r_quad    <= QUAD_0;
      r_sin_idx <= 7'd0;
      r_cos_idx <= 7'd90;
    end else begin
      r_quad    <= w_quad;
      r_sin_idx <= w_sin_full[6:0];
      r_cos_idx <= w_cos_full[6:0];
    end
  end

  logic [31:0] w_sin_mag;
  logic [31:0] w_cos_mag;
  logic        w_sin_neg;
  logic        w_cos_neg;

  assign w_sin_mag = {21'd0, sin_lut(r_sin_idx)};
  assign w_cos_mag = {21'd0, sin_lut(r_cos_idx)};
  assign w_sin_neg = (r_quad == QUAD_2) || (r_quad == QUAD_3);
  assign w_cos_neg = (r_quad == QUAD_1) || (r_quad == QUAD_2);

  // Two's complement of a zero magnitude is zero, so no negative-zero pattern can appear.
  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      o_sin <= 32'd0;
      o_cos <= SCALE;
    end else begin
      o_sin <= w_sin_neg ? (32'd0 - w_sin_mag) : w_sin_mag;
      o_cos <= w_cos_neg ? (32'd0 - w_cos_mag) : w_cos_mag;
    end
  end

endmodule

// File: tb/tb_trigonometry_unit.sv
// Directed self-checking bench for trigonometry_unit: reset, anchors, wrap, pipelining, full sweep.
module tb_trigonometry_unit;

  logic               clk = 1'b0;
  logic               rst;
  logic [31:0]        theta;
  logic signed [31:0] sin_o;
  logic signed [31:0] cos_o;

  int n_vec = 0;
  int n_err = 0;

  trigonometry_unit dut (
    .i_CLK   (clk),
    .i_RESET (rst),
    .i_theta (theta),
    .o_cos   (cos_o),
    .o_sin   (sin_o)
  );

  always #5 clk = ~clk;

  function automatic int round_away(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    else          return -$rtoi(-x + 0.5);
  endfunction

  task automatic test_reset();
    rst   = 1'b1;
    theta = 32'd123;
    #1;
    n_vec++;
    if (sin_o !== 32'sd0 || cos_o !== 32'sd1024) begin
      n_err++;
      $display("FAIL reset_initial: got sin=%0d cos=%0d, want sin=0 cos=1024", sin_o, cos_o);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (sin_o !== 32'sd0 || cos_o !== 32'sd1024) begin
      n_err++;
      $display("FAIL reset_hold_edge1: got sin=%0d cos=%0d, want sin=0 cos=1024", sin_o, cos_o);
    end
    @(posedge clk); #1;
    // sin 123 = sin 57 = 858.80 -> 859; cos 123 = -sin 33 = -557.71 -> -558
    n_vec++;
    if (sin_o !== 32'sd859 || cos_o !== -32'sd558) begin
      n_err++;
      $display("FAIL reset_first_result: got sin=%0d cos=%0d, want sin=859 cos=-558", sin_o, cos_o);
    end
    // Mid-cycle reset must clear the outputs without a clock edge.
    theta = 32'd45;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    n_vec++;
    if (sin_o !== 32'sd0 || cos_o !== 32'sd1024) begin
      n_err++;
      $display("FAIL reset_async_mid: got sin=%0d cos=%0d, want sin=0 cos=1024", sin_o, cos_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (sin_o !== 32'sd0 || cos_o !== 32'sd1024) begin
      n_err++;
      $display("FAIL reset_discard_inflight: got sin=%0d cos=%0d, want sin=0 cos=1024", sin_o, cos_o);
    end
    @(posedge clk); #1;
    n_vec++;
    if (sin_o !== 32'sd724 || cos_o !== 32'sd724) begin
      n_err++;
      $display("FAIL reset_after_release: got sin=%0d cos=%0d, want sin=724 cos=724", sin_o, cos_o);
    end
  endtask

  task automatic test_directed();
    logic [31:0] v_theta [15];
    logic [31:0] v_sin   [15];
    logic [31:0] v_cos   [15];
    v_theta = '{32'd0, 32'd30, 32'd45, 32'd60, 32'd90, 32'd180, 32'd270, 32'd359,
                32'd360, 32'd450, 32'd511, 32'h0000_022D, 32'hFFFF_FE2D, 32'd123, 32'd1};
    v_sin   = '{32'd0, 32'd512, 32'd724, 32'd887, 32'd1024, 32'd0, 32'hFFFF_FC00, 32'hFFFF_FFEE,
                32'd0, 32'd1024, 32'd496, 32'd724, 32'd724, 32'd859, 32'd18};
    v_cos   = '{32'd1024, 32'd887, 32'd724, 32'd512, 32'd0, 32'hFFFF_FC00, 32'd0, 32'd1024,
                32'd1024, 32'd0, 32'hFFFF_FC80, 32'd724, 32'd724, 32'hFFFF_FDD2, 32'd1024};
    for (int i = 0; i < 15; i++) begin
      theta = v_theta[i];
      @(posedge clk); #1;
      @(posedge clk); #1;
      n_vec++;
      if (sin_o !== v_sin[i] || cos_o !== v_cos[i]) begin
        n_err++;
        $display("FAIL directed theta=0x%08h: got sin=0x%08h cos=0x%08h, want sin=0x%08h cos=0x%08h",
                 v_theta[i], sin_o, cos_o, v_sin[i], v_cos[i]);
      end
    end
    // Held input keeps the output steady.
    @(posedge clk); #1;
    n_vec++;
    if (sin_o !== 32'sd18 || cos_o !== 32'sd1024) begin
      n_err++;
      $display("FAIL held_input: got sin=%0d cos=%0d, want sin=18 cos=1024", sin_o, cos_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] b_theta [6];
    int          b_sin   [6];
    int          b_cos   [6];
    b_theta = '{32'd0, 32'd90, 32'd180, 32'd270, 32'd135, 32'd225};
    b_sin   = '{0, 1024, 0, -1024, 724, -724};
    b_cos   = '{1024, 0, -1024, 0, -724, -724};
    for (int i = 0; i < 8; i++) begin
      if (i >= 2) begin
        n_vec++;
        if (sin_o !== b_sin[i-2] || cos_o !== b_cos[i-2]) begin
          n_err++;
          $display("FAIL back_to_back theta=%0d: got sin=%0d cos=%0d, want sin=%0d cos=%0d",
                   b_theta[i-2], sin_o, cos_o, b_sin[i-2], b_cos[i-2]);
        end
      end
      if (i < 6) theta = b_theta[i];
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sweep();
    real    rad;
    int     es;
    int     ec;
    longint mag2;
    for (int i = 0; i < 362; i++) begin
      if (i >= 2) begin
        rad = real'(i - 2) * 3.14159265358979323846 / 180.0;
        es  = round_away(1024.0 * $sin(rad));
        ec  = round_away(1024.0 * $cos(rad));
        n_vec++;
        if (sin_o !== es || cos_o !== ec) begin
          n_err++;
          $display("FAIL sweep a=%0d: got sin=%0d cos=%0d, want sin=%0d cos=%0d",
                   i - 2, sin_o, cos_o, es, ec);
        end
        mag2 = longint'(sin_o) * longint'(sin_o) + longint'(cos_o) * longint'(cos_o);
        n_vec++;
        if (mag2 < 64'sd1046528 || mag2 > 64'sd1050624) begin
          n_err++;
          $display("FAIL sweep_norm a=%0d: got sin^2+cos^2=%0d, want 1048576+-2048", i - 2, mag2);
        end
        n_vec++;
        if (sin_o < -32'sd1024 || sin_o > 32'sd1024 || cos_o < -32'sd1024 || cos_o > 32'sd1024 ||
            sin_o === 32'h8000_0000 || cos_o === 32'h8000_0000) begin
          n_err++;
          $display("FAIL sweep_range a=%0d: got sin=0x%08h cos=0x%08h, want magnitude <= 1024",
                   i - 2, sin_o, cos_o);
        end
      end
      if (i < 360) theta = 32'(i);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
